// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the multiplexed 4-digit seven-segment scan driver:
// glyph table (a..g, active-high, bit 0 = a), register bundle type and width helper.
package seg_scan_driver_pkg;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } frame_t;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/seg_scan_driver_hex_decode.sv
// Combinational hex nibble to seven-segment glyph lookup (a..g, active-high).
module seg_hex_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver with anti-ghost blanking
// and frame-synchronous double-buffered display data.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 64,
  parameter int SEG_ACT_LOW  = 1,
  parameter int DIG_ACT_LOW  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  output logic [11:0] seg,
  output logic        frame_done
);

  localparam int PERIOD = CLK_HZ / SCAN_HZ;
  localparam int CW     = (clog2(PERIOD) < 1) ? 1 : clog2(PERIOD);

  localparam logic [CW-1:0] SLOT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [3:0]    DIG_OFF   = {4{DIG_ACT_LOW != 0}};
  localparam logic [7:0]    SEG_OFF   = {8{SEG_ACT_LOW != 0}};

  if (PERIOD < 1 || BLANK_CYCLES < 0 || BLANK_CYCLES >= PERIOD) begin : g_bad_params
    $error("seg_scan_driver: BLANK_CYCLES must satisfy 0 <= BLANK_CYCLES < CLK_HZ/SCAN_HZ");
  end

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  frame_t        shadow;
  frame_t        active;
  frame_t        incoming;
  logic          slot_end;
  logic          frame_wrap;
  logic          wrap_q;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic [3:0]    dig_raw;
  logic [7:0]    seg_raw;

  assign incoming   = '{data: data_in, dp: dp_in, blank: blank_in};
  assign slot_end   = (cnt == SLOT_LAST);
  assign frame_wrap = slot_end && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load landing on the wrap edge bypasses the shadow so the new frame shows it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (load) shadow <= incoming;
      if (frame_wrap) active <= load ? incoming : shadow;
    end
  end

  assign nibble = active.data[{idx, 2'b00} +: 4];

  seg_hex_decode u_hex_decode (
    .nibble (nibble),
    .glyph  (glyph)
  );

  always_comb begin
    dig_raw = '0;
    seg_raw = '0;
    if (cnt >= BLANK_END) begin
      if (!active.blank[idx]) dig_raw[idx] = 1'b1;
      seg_raw = {active.dp[idx], glyph};
    end
  end

  // frame_done lines up with the first registered output of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= {DIG_OFF, SEG_OFF};
      wrap_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      seg        <= {dig_raw ^ DIG_OFF, seg_raw ^ SEG_OFF};
      wrap_q     <= frame_wrap;
      frame_done <= wrap_q;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, digit slot rate in Hz; PERIOD = CLK_HZ/SCAN_HZ cycles per slot.
REQ-003 Parameter BLANK_CYCLES, default 64, anti-ghost blank cycles at the start of each slot; legal range 0 <= BLANK_CYCLES < PERIOD.
REQ-004 Parameter SEG_ACT_LOW, default 1, sets segment output polarity (1 = lit when 0).
REQ-005 Parameter DIG_ACT_LOW, default 1, sets digit-select polarity (1 = enabled when 0).
REQ-006 clk  input  1  system clock; all state is clocked on the rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 data_in  input  16  four hex nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-009 dp_in  input  4  decimal-point enable per digit; bit n = digit n.
REQ-010 blank_in  input  4  per-digit blank mask; 1 = digit n dark.
REQ-011 load  input  1  single-cycle strobe that captures data_in, dp_in and blank_in.
REQ-012 seg  output  12  {dig_sel[3:0], dp, g, f, e, d, c, b, a}; dig_sel bit n drives digit n.
REQ-013 frame_done  output  1  one-cycle pulse when the displayed frame wraps.

Function
REQ-014 A slot counter SHALL count 0..PERIOD-1 and wrap; the digit index SHALL increment on each wrap, 0->1->2->3->0.
REQ-015 For slot counter < BLANK_CYCLES, all dig_sel bits and all segment bits SHALL be inactive.
REQ-016 For slot counter >= BLANK_CYCLES, only dig_sel[idx] SHALL be active, unless active-blank[idx] = 1, in which case all digits SHALL be inactive.
REQ-017 Segments SHALL show the hex glyph 0-F of active-nibble[idx]; dp SHALL equal active-dp[idx].
REQ-018 seg SHALL be registered, and its value SHALL reflect counter/index state with exactly 1 cycle of latency.
REQ-019 load SHALL write data_in, dp_in and blank_in into a shadow register on the same edge.
REQ-020 The active register SHALL update from shadow only at the frame wrap (idx 3->0), so that no frame mixes old and new data.
REQ-021 If load coincides with the frame wrap, the active register SHALL take data_in, dp_in and blank_in directly, and shadow SHALL also take them.
REQ-022 frame_done SHALL assert for one cycle, on the edge after the idx 3->0 transition.
REQ-023 load held high for multiple cycles SHALL behave as repeated loads; the last value SHALL win.
REQ-024 Polarity SHALL be applied only at the output register, according to SEG_ACT_LOW and DIG_ACT_LOW.

Reset
REQ-025 While rst_n = 0: slot counter 0, idx 0, shadow and active registers 0 (blank mask 0), frame_done 0.
REQ-026 While rst_n = 0, seg SHALL be all inactive: 12'hFFF with both polarity parameters at 1.
REQ-027 After rst_n deasserts, the first slot SHALL begin at counter 0 with the blank phase.
REQ-028 Reset asserted mid-slot SHALL immediately force all outputs inactive, with no partial-cycle glitch to an active state.

Structure
REQ-029 A shared package/include SHALL hold the 16-entry hex-to-segment constant table (a..g, active-high) and the clog2 helper for the counter width.
REQ-030 The block SHALL contain one sub-module, seg_hex_decode: combinational 4-bit nibble to 7-bit glyph.
REQ-031 Counter width SHALL be clog2(PERIOD); the elaboration SHALL fail if BLANK_CYCLES >= PERIOD.

Verification (CLK_HZ=1000, SCAN_HZ=100 -> PERIOD=10, BLANK_CYCLES=2, both polarities active-low)
REQ-032 Reset -> seg = 12'hFFF; after release, cycles 1-2 are blank, then dig_sel = 4'b1110.
REQ-033 load data_in=16'h12AF, dp_in=4'b0001, blank_in=0 -> next frame: digit0 = F with dp lit (seg[7:0]=8'h0E), digit1 = A (8'h88), digit2 = 2 (8'hA4), digit3 = 1 (8'hF9).
REQ-034 load mid-frame during digit1 -> digits 2-3 of that frame keep the old value; the new value appears from the next digit0; frame_done pulses every 40 cycles.
REQ-035 load asserted on the exact wrap cycle -> the new value is shown in the digit0 slot that starts on that wrap.
REQ-036 blank_in=4'b0100 -> during the digit2 slot, dig_sel = 4'b1111 for all 10 cycles.
REQ-037 rst_n pulsed low during digit3 active phase -> seg = 12'hFFF asynchronously; restart at idx 0 with active data = 0.
